// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer: USR select codes,
// command opcodes and the sequencer FSM states.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SHL  = 2'd1,
        OP_SHR  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Select code driven to the chain while a non-LOAD command is running.
    function automatic logic [1:0] sel_for_op(input op_e op);
        logic [1:0] sel;
        sel = SEL_HOLD;
        case (op)
            OP_SHL:  sel = SEL_SHL;
            OP_SHR:  sel = SEL_SHR;
            OP_LOAD: sel = SEL_LOAD;
            default: sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register chain: accepts one command per
// handshake, drives select/data/serial inputs, and returns the chain contents with done.
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] d_in,
    output logic             ser_lsb,
    output logic             ser_msb,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic [WIDTH-1:0] result_data
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fill_q, fill_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        count_d  = count_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    data_d  = cmd_data;
                    count_d = cmd_count;
                    fill_d  = cmd_fill;
                    if (op_e'(cmd_op) == OP_LOAD) begin
                        state_d = LOAD;
                    end else if (cmd_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            LOAD: begin
                state_d = DONE;
            end
            RUN: begin
                // Leave after exactly cmd_count cycles: exit when the decremented value hits zero.
                count_d = count_q - CNT_W'(1);
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = q_in;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_HOLD;
            data_q   <= '0;
            count_q  <= '0;
            fill_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            count_q  <= count_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Chain controls depend only on registered state, never on cmd_* directly.
    always_comb begin
        select  = SEL_HOLD;
        d_in    = '0;
        ser_lsb = 1'b0;
        ser_msb = 1'b0;
        case (state_q)
            LOAD: begin
                select = SEL_LOAD;
                d_in   = data_q;
            end
            RUN: begin
                select = sel_for_op(op_q);
                if (op_q == OP_SHL) ser_lsb = fill_q;
                if (op_q == OP_SHR) ser_msb = fill_q;
            end
            default: begin
                select = SEL_HOLD;
            end
        endcase
    end

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign done        = done_q;
    assign result_data = result_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench: usr_seq_ctrl driving a 4-cell universal shift register, checked
// against a command-level reference model through per-cycle and per-result scoreboards.
module tb_usr_seq_ctrl;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [1:0]       select;
    logic [WIDTH-1:0] d_in;
    logic             ser_lsb;
    logic             ser_msb;
    logic [WIDTH-1:0] chain = '0;
    logic             done;
    logic [WIDTH-1:0] result_data;

    usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .select(select), .d_in(d_in), .ser_lsb(ser_lsb), .ser_msb(ser_msb),
        .q_in(chain), .done(done), .result_data(result_data)
    );

    always #5 clk = ~clk;

    // The controlled USR chain.
    always_ff @(posedge clk) begin
        case (select)
            SEL_SHL:  chain <= {chain[WIDTH-2:0], ser_lsb};
            SEL_SHR:  chain <= {ser_msb, chain[WIDTH-1:1]};
            SEL_LOAD: chain <= d_in;
            default:  chain <= chain;
        endcase
    end

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] d;
        logic             sl;
        logic             sm;
    } cyc_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        int               acc;
    } res_t;

    cyc_t             cyc_q[$];
    res_t             res_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic             exp_ready = 1'b0;
    logic [WIDTH-1:0] mv = '0;
    logic [WIDTH-1:0] last_result = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: on each accepted command, compute the final value and per-cycle drive.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst && cmd_valid && exp_ready) begin
                cyc_t c;
                res_t r;
                r.acc = cyc;
                if (cmd_op == OP_LOAD) begin
                    c = '{sel: SEL_LOAD, d: cmd_data, sl: 1'b0, sm: 1'b0};
                    cyc_q.push_back(c);
                    mv = cmd_data;
                    r.lat = 3;
                end else begin
                    for (int i = 0; i < int'(cmd_count); i++) begin
                        c = '{sel: SEL_HOLD, d: '0, sl: 1'b0, sm: 1'b0};
                        if (cmd_op == OP_SHL) begin
                            c.sel = SEL_SHL;
                            c.sl  = cmd_fill;
                            mv    = WIDTH'((int'(mv) * 2 + int'(cmd_fill)) % 16);
                        end else if (cmd_op == OP_SHR) begin
                            c.sel = SEL_SHR;
                            c.sm  = cmd_fill;
                            mv    = WIDTH'(int'(mv) / 2 + int'(cmd_fill) * 8);
                        end
                        cyc_q.push_back(c);
                    end
                    r.lat = int'(cmd_count) + 2;
                end
                c = '{sel: SEL_HOLD, d: '0, sl: 1'b0, sm: 1'b0};
                cyc_q.push_back(c);
                r.res = mv;
                res_q.push_back(r);
            end
        end
    end

    // Monitor: compares every cycle's drive and every done against the scoreboards.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ready = 1'b0;
            end else begin
                cyc_t e;
                if (cyc_q.size() > 0) begin
                    e = cyc_q.pop_front();
                    exp_ready = 1'b0;
                end else begin
                    e = '{sel: SEL_HOLD, d: '0, sl: 1'b0, sm: 1'b0};
                    exp_ready = 1'b1;
                end
                check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
                check("select", 32'(select), 32'(e.sel));
                check("d_in", 32'(d_in), 32'(e.d));
                check("ser_lsb", 32'(ser_lsb), 32'(e.sl));
                check("ser_msb", 32'(ser_msb), 32'(e.sm));
                if (done) begin
                    if (res_q.size() == 0) begin
                        check("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        check("result", 32'(result_data), 32'(r.res));
                        check("latency", 32'(cyc - r.acc + 1), 32'(r.lat));
                        last_result = r.res;
                    end
                end else begin
                    check("result_hold", 32'(result_data), 32'(last_result));
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] cnt, input logic fill);
        int tries;
        logic ok;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        cmd_fill  = fill;
        tries = 0;
        ok = 1'b0;
        while (!ok && tries < 100) begin
            @(negedge clk);
            ok = cmd_ready;
            tries++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic busy_pulse();
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'b0000;
        cmd_count = 4'd3;
        cmd_fill  = 1'b1;
        @(negedge clk);
        check("busy_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_data = '0;
        cmd_count = '0;
        cmd_fill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_select", 32'(select), 32'd0);
        check("rst_d_in", 32'(d_in), 32'd0);
        check("rst_ser", 32'({ser_lsb, ser_msb}), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result_data), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        #2 rst = 1'b0;

        // Reset in the middle of a 5-cycle shift-left, two shifts in.
        send(OP_LOAD, 4'b0010, 4'd0, 1'b0);
        send(OP_SHL, 4'b0000, 4'd5, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_select", 32'(select), 32'(SEL_HOLD));
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        check("midrst_chain", 32'(chain), 32'(4'b1000));
        cyc_q.delete();
        res_q.delete();
        last_result = '0;
        mv = 4'b1000;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_chain", 32'(chain), 32'(4'b1000));
        check("postrst_ready", 32'(cmd_ready), 32'd1);

        // LOAD, then shifts left and right.
        send(OP_LOAD, 4'b1010, 4'd7, 1'b1);
        @(posedge clk);
        #1;
        check("load_chain", 32'(chain), 32'(4'b1010));
        send(OP_SHL, 4'b0000, 4'd2, 1'b1);
        send(OP_SHR, 4'b1111, 4'd1, 1'b0);

        // HOLD and zero-length commands leave the chain alone.
        send(OP_LOAD, 4'b0110, 4'd0, 1'b0);
        send(OP_HOLD, 4'b0000, 4'd3, 1'b1);
        send(OP_SHR, 4'b0000, 4'd0, 1'b1);
        send(OP_SHL, 4'b0000, 4'd0, 1'b1);

        // Back-to-back with cmd_valid held high.
        send(OP_LOAD, 4'b1111, 4'd0, 1'b0);
        send(OP_SHR, 4'b0000, 4'd1, 1'b0);

        // Requests while busy must be ignored.
        send(OP_HOLD, 4'b0000, 4'd4, 1'b0);
        busy_pulse();
        send(OP_LOAD, 4'b1001, 4'd0, 1'b0);
        busy_pulse();

        // Maximum count.
        send(OP_SHR, 4'b0000, 4'd15, 1'b1);

        for (int i = 0; i < 60; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 6)),
                 1'($urandom));
            if ($urandom_range(0, 3) == 0) busy_pulse();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        waited = 0;
        while (res_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_empty", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
